// File: rtl/apb_master.sv
// APB requester: one host request at a time, SETUP then ACCESS on PSEL1/PSEL2; 3-cycle turnaround with zero wait states.
// Host is backpressured through req_ready (high only in IDLE); ACCESS aborts with resp_err after TIMEOUT unready cycles.
module apb_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W:0]   req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              PSEL1,
    output logic              PSEL2,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA1,
    input  logic [DATA_W-1:0] PRDATA2,
    input  logic              PREADY
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              psel1_q, psel1_d;
    logic              psel2_q, psel2_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;

    always_comb begin
        state_d      = state_q;
        psel1_d      = psel1_q;
        psel2_d      = psel2_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        wait_cnt_d   = wait_cnt_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    pwrite_d  = req_write;
                    paddr_d   = req_addr[ADDR_W-1:0];
                    pwdata_d  = req_wdata;
                    psel1_d   = ~req_addr[ADDR_W];
                    psel2_d   = req_addr[ADDR_W];
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d  = 1'b1;
                wait_cnt_d = '0;
                state_d    = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    psel1_d      = 1'b0;
                    psel2_d      = 1'b0;
                    penable_d    = 1'b0;
                    resp_rdata_d = pwrite_q ? '0 : (psel2_q ? PRDATA2 : PRDATA1);
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    state_d      = IDLE;
                end else if ((TIMEOUT != 0) && (wait_cnt_q == TO_LAST)) begin
                    psel1_d      = 1'b0;
                    psel2_d      = 1'b0;
                    penable_d    = 1'b0;
                    resp_rdata_d = '0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    state_d      = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= IDLE;
            psel1_q      <= 1'b0;
            psel2_q      <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            psel1_q      <= psel1_d;
            psel2_q      <= psel2_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign req_ready  = (state_q == IDLE) & ~PRESET;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign PSEL1      = psel1_q;
    assign PSEL2      = psel2_q;
    assign PENABLE    = penable_q;
    assign PWRITE     = pwrite_q;
    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: two 8-bit memory slaves with programmable stall/hang on PREADY.
module tb_apb_master;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [8:0] req_addr;
    logic [7:0] req_wdata;
    logic       resp_valid;
    logic [7:0] resp_rdata;
    logic       resp_err;
    logic       PSEL1, PSEL2, PENABLE, PWRITE;
    logic [7:0] PADDR, PWDATA, PRDATA1, PRDATA2;
    logic       PREADY;

    logic [7:0] mem1 [256];
    logic [7:0] mem2 [256];
    int         stall_cnt;
    int         n_stall;
    logic       hang;

    int n_checks;
    int n_fail;
    int lat;

    apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(15), .TO_W(4)) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .PSEL1      (PSEL1),
        .PSEL2      (PSEL2),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA1    (PRDATA1),
        .PRDATA2    (PRDATA2),
        .PREADY     (PREADY)
    );

    always #5 PCLK = ~PCLK;

    // Slaves: PREADY comes after n_stall unready ACCESS cycles, never while hang is set.
    assign PREADY  = (PSEL1 | PSEL2) & PENABLE & ~hang & (stall_cnt >= n_stall);
    assign PRDATA1 = mem1[PADDR];
    assign PRDATA2 = mem2[PADDR];

    always @(posedge PCLK) begin
        if (PRESET || !((PSEL1 | PSEL2) && PENABLE) || PREADY) stall_cnt <= 0;
        else stall_cnt <= stall_cnt + 1;
        if (PRESET && !(PSEL1 | PSEL2)) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= 8'h00;
                mem2[i] <= 8'h00;
            end
        end else if (PENABLE && PREADY && PWRITE) begin
            if (PSEL1) mem1[PADDR] <= PWDATA;
            if (PSEL2) mem2[PADDR] <= PWDATA;
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Presents one request, checks SETUP/ACCESS phases, returns edges from accept to resp_valid.
    task automatic xfer(input logic w, input logic [8:0] a, input logic [7:0] d, output int edges);
        int unstable;
        unstable  = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        check("accept_ready", {15'd0, req_ready}, 16'd1);
        tick();
        req_valid = 1'b0;
        check("setup_sel", {14'd0, PSEL2, PSEL1}, a[8] ? 16'd2 : 16'd1);
        check("setup_penable", {15'd0, PENABLE}, 16'd0);
        check("setup_addr_dir", {7'd0, PWRITE, PADDR}, {7'd0, w, a[7:0]});
        edges = 0;
        while (!resp_valid && edges < 40) begin
            tick();
            edges++;
            if (!resp_valid && (PADDR !== a[7:0] || PWDATA !== d || PENABLE !== 1'b1))
                unstable++;
        end
        check("access_stable", 16'(unstable), 16'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        n_stall   = 0;
        hang      = 1'b0;
        PRESET    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        tick();
        tick();
        check("rst_ready", {15'd0, req_ready}, 16'd0);
        check("rst_ctl", {11'd0, PSEL1, PSEL2, PENABLE, PWRITE, resp_valid}, 16'd0);
        check("rst_data", {PADDR, PWDATA}, 16'h0000);
        check("rst_resp", {7'd0, resp_err, resp_rdata}, 16'd0);
        PRESET = 1'b0;
        #1;
        check("post_rst_ready", {15'd0, req_ready}, 16'd1);

        // Write 0xA5 to slave1 @0x05, zero wait states.
        xfer(1'b1, 9'h005, 8'hA5, lat);
        check("wr1_lat", 16'(lat), 16'd2);
        check("wr1_resp", {7'd0, resp_err, resp_rdata}, 16'h0000);
        check("wr1_sel_drop", {14'd0, PSEL1, PENABLE}, 16'd0);

        xfer(1'b0, 9'h005, 8'h00, lat);
        check("rd1_lat", 16'(lat), 16'd2);
        check("rd1_data", {7'd0, resp_err, resp_rdata}, 16'h00A5);
        tick();
        check("rd1_pulse_clear", {15'd0, resp_valid}, 16'd0);
        check("rd1_data_hold", {8'd0, resp_rdata}, 16'h00A5);
        check("idle_hold", {PADDR, 7'd0, PWRITE}, 16'h0500);

        // Slave2 path.
        xfer(1'b1, 9'h10A, 8'h3C, lat);
        check("wr2_lat", 16'(lat), 16'd2);
        xfer(1'b0, 9'h10A, 8'h00, lat);
        check("rd2_data", {8'd0, resp_rdata}, 16'h003C);
        xfer(1'b0, 9'h00A, 8'h00, lat);
        check("rd_s1_alias", {8'd0, resp_rdata}, 16'h0000);

        // Two wait states.
        n_stall = 2;
        xfer(1'b1, 9'h021, 8'h5E, lat);
        check("wait2_lat", 16'(lat), 16'd4);
        check("wait2_err", {15'd0, resp_err}, 16'd0);
        n_stall = 0;

        // Timeout abort after 15 unready ACCESS cycles.
        hang = 1'b1;
        xfer(1'b0, 9'h005, 8'h00, lat);
        check("to_lat", 16'(lat), 16'd16);
        check("to_resp", {7'd0, resp_err, resp_rdata}, 16'h0100);
        check("to_sel_drop", {13'd0, PSEL1, PSEL2, PENABLE}, 16'd0);
        hang = 1'b0;
        xfer(1'b0, 9'h005, 8'h00, lat);
        check("after_to_rd", {7'd0, resp_err, resp_rdata}, 16'h00A5);
        check("after_to_lat", 16'(lat), 16'd2);

        // Reset mid-ACCESS abandons the transfer.
        hang      = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 9'h133;
        req_wdata = 8'hEE;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("pre_rst_access", {14'd0, PSEL2, PENABLE}, 16'd3);
        PRESET = 1'b1;
        tick();
        check("mid_rst_ctl", {11'd0, PSEL1, PSEL2, PENABLE, PWRITE, resp_valid}, 16'd0);
        check("mid_rst_data", {PADDR, PWDATA}, 16'h0000);
        check("mid_rst_ready", {15'd0, req_ready}, 16'd0);
        PRESET = 1'b0;
        hang   = 1'b0;
        #1;
        check("mid_rst_ready_rel", {15'd0, req_ready}, 16'd1);
        lat = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (resp_valid) lat++;
        end
        check("mid_rst_no_resp", 16'(lat), 16'd0);

        // Back-to-back: B is accepted in the resp_valid cycle of A.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 9'h033;
        req_wdata = 8'h77;
        tick();
        req_write = 1'b0;
        req_wdata = 8'h00;
        tick();
        check("b2b_ignore_busy", {PADDR, 7'd0, PWRITE}, 16'h3301);
        tick();
        check("b2b_a_resp", {14'd0, resp_valid, req_ready}, 16'd3);
        tick();
        req_valid = 1'b0;
        check("b2b_b_accept", {13'd0, resp_valid, PSEL1, PWRITE}, 16'd2);
        tick();
        tick();
        check("b2b_b_resp", {7'd0, resp_valid, resp_rdata}, 16'h0177);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Single-clock APB requester (bridge) that sits directly upstream of the two 8-bit APB memory slaves (slave1, slave2).
- Accepts one read or write request at a time from a simple valid/ready host port, and runs the APB SETUP -> ACCESS sequence toward the selected slave.
- Returns read data or write completion as a one-cycle response pulse.
- Aborts with an error if PREADY never arrives within a programmable wait limit.

Parameters:
- ADDR_W, 8, width of PADDR; host address is ADDR_W+1 bits, with the MSB as slave select.
- DATA_W, 8, width of PWDATA/PRDATA and host data.
- TIMEOUT, 15, maximum ACCESS cycles with PREADY=0 before abort; 0 disables the timeout.
- TO_W, 4, wait counter width; TIMEOUT must be <= 2^TO_W - 1.

Ports:
- PCLK  input  1  clock; all state changes on the rising edge.
- PRESET  input  1  synchronous reset, active-high.
- req_valid  input  1  host request valid.
- req_ready  output  1  host request ready; equals (state==IDLE) & ~PRESET.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W+1  [ADDR_W] selects slave (0 = slave1, 1 = slave2); [ADDR_W-1:0] is forwarded to PADDR.
- req_wdata  input  DATA_W  write data.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  DATA_W  read data; 0 for writes and errors.
- resp_err  output  1  qualifies resp_valid; 1 = timeout abort.
- PSEL1  output  1  APB select, slave1.
- PSEL2  output  1  APB select, slave2.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PADDR  output  ADDR_W  APB address.
- PWDATA  output  DATA_W  APB write data.
- PRDATA1  input  DATA_W  read data from slave1.
- PRDATA2  input  DATA_W  read data from slave2.
- PREADY  input  1  ready from the selected slave; the two slaves' PREADY are ORed externally.

Behaviour:
- All outputs are registered except req_ready.
- Reset (PRESET=1 at a rising edge):
  - state becomes IDLE.
  - PSEL1, PSEL2, PENABLE, PWRITE, resp_valid and resp_err become 0.
  - PADDR, PWDATA and resp_rdata become 0.
  - wait counter becomes 0.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready=1. On req_valid at an edge, capture req_write into PWRITE, req_addr[ADDR_W-1:0] into PADDR and req_wdata into PWDATA.
  - Assert exactly one of PSEL1/PSEL2 per req_addr[ADDR_W], keep PENABLE=0, and go to SETUP.
  - Without req_valid, stay in IDLE.
- SETUP:
  - Lasts exactly one cycle; PENABLE=0.
  - Next edge: PENABLE=1, clear wait counter, go to ACCESS.
- ACCESS:
  - PENABLE=1; PSELx, PADDR, PWRITE and PWDATA are held stable.
  - At each edge, if PREADY=1:
    - Drop PSELx and PENABLE.
    - For a read, load resp_rdata from PRDATA1 or PRDATA2 (the selected slave); for a write, load 0.
    - resp_valid=1, resp_err=0, go to IDLE.
  - If PREADY=0 and TIMEOUT!=0 and the wait counter equals TIMEOUT-1: abort, with PSELx/PENABLE dropped, resp_valid=1, resp_err=1, resp_rdata=0, go to IDLE.
  - Otherwise increment the wait counter and stay in ACCESS.
- resp_valid is high for exactly one cycle (the first IDLE cycle after completion), then cleared.
- resp_rdata and resp_err hold their values until the next response.
- Latency with zero wait states: request accepted at edge E0, SETUP visible E0..E1, ACCESS E1..E2, resp_valid high E2..E3. Each PREADY=0 cycle adds one.
- Back-to-back: a new request may be accepted in the same cycle resp_valid is high, so the steady state is 3 cycles per transfer.
- PADDR, PWDATA and PWRITE keep their last values while IDLE; no APB signal toggles without a request.
- PSEL1 and PSEL2 are never both 1.
- PRESET during SETUP or ACCESS:
  - Transfer abandoned at that edge; all outputs take reset values.
  - No resp_valid is produced for the abandoned request.
- req_valid while not in IDLE is ignored; the host must hold the request until req_ready=1.

Test Plan:
- Reset then write req_addr=0x005, wdata=0xA5 -> PSEL1=1/PENABLE=0 for 1 cycle, then PENABLE=1. Slave1 PREADY completes immediately; resp_valid pulses 3 cycles after accept with resp_err=0 and resp_rdata=0x00.
- Read req_addr=0x005 after that write -> PWRITE=0, PSEL1 path, resp_rdata=0xA5.
- Write req_addr=0x10A, wdata=0x3C, then read 0x10A -> only PSEL2 asserts, PADDR=0x0A, resp_rdata=0x3C. A read of 0x00A does not return 0x3C.
- Force PREADY=0 for 2 ACCESS cycles, then 1 -> response 5 cycles after accept; PADDR/PWDATA stable throughout.
- Hold PREADY=0 with TIMEOUT=15 -> abort after 15 ACCESS cycles: resp_valid=1, resp_err=1, resp_rdata=0, PSEL/PENABLE=0. Next request proceeds normally.
- Assert PRESET for one cycle during ACCESS -> all outputs zero at the next edge, no resp_valid, req_ready=1 after PRESET drops. Then issue two back-to-back requests -> the second is accepted in the resp_valid cycle of the first.
